// File: rtl/rm8s_div_if.sv
// rm8s_div_if: operand/result handshake bundle for the rm8s_div signed divider.
//   in_valid/in_ready   operand handshake (product, b)
//   product             signed dividend, 2*W_IN bits
//   b                   signed divisor, W_IN bits
//   out_valid/out_ready result handshake (a, rem, ovf, div0)
//   a                   signed quotient, truncated toward zero
//   rem                 signed remainder, sign of the dividend
//   ovf                 quotient outside the W_IN-bit signed range
//   div0                divisor was zero
// master: operand producer / result consumer. slave: the divider.
interface rm8s_div_if #(
  parameter int unsigned W_IN = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*W_IN-1:0]     product;
  logic [W_IN-1:0]       b;
  logic                  out_valid;
  logic                  out_ready;
  logic [W_IN-1:0]       a;
  logic [W_IN-1:0]       rem;
  logic                  ovf;
  logic                  div0;

  modport master (
    output in_valid, product, b, out_ready,
    input  in_ready, out_valid, a, rem, ovf, div0
  );

  modport slave (
    input  in_valid, product, b, out_ready,
    output in_ready, out_valid, a, rem, ovf, div0
  );
endinterface

// File: rtl/rm8s_div.sv
// rm8s_div: sequential restoring signed divider, one quotient bit per cycle.
// Divides a 2*W_IN-bit signed product by a W_IN-bit signed factor and returns
// the other factor as quotient plus remainder. Result appears 17 edges after
// the accept edge (IDLE -> BUSY x16 -> FIX -> DONE), held until out_ready.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any in-flight operation
//   bus    rm8s_div_if slave modport (operand and result handshakes)
module rm8s_div #(
  parameter int unsigned W_IN = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rm8s_div_if.slave      bus
);
  localparam int unsigned WD = 2 * W_IN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic            sp;
  logic            sb;
  logic [WD-1:0]   dmag;     // dividend magnitude, becomes quotient magnitude
  logic [W_IN-1:0] bmag;
  logic [W_IN-1:0] prem;     // partial remainder
  logic [W_IN-1:0] prod_lo;
  logic [3:0]      cnt;

  logic            in_ready_r;
  logic            out_valid_r;
  logic [W_IN-1:0] a_r;
  logic [W_IN-1:0] rem_r;
  logic            ovf_r;
  logic            div0_r;

  // Restoring step. The shifted remainder is W_IN+1 bits wide; its top bit
  // (prem MSB) alone guarantees it is >= bmag, and the difference always fits
  // in W_IN bits, so the W_IN-bit register holds the full partial remainder.
  logic [W_IN-1:0] shl_lo;
  logic            ge;
  logic [W_IN-1:0] diff;

  always_comb begin
    shl_lo = {prem[W_IN-2:0], dmag[WD-1]};
    ge     = prem[W_IN-1] | (shl_lo >= bmag);
    diff   = shl_lo - bmag;
  end

  // Sign fix-up in WD+1 bits so that a 32768 magnitude negates cleanly.
  logic [WD:0]     qmag;
  logic [WD:0]     q_s;
  logic [W_IN-1:0] r_s;
  logic            q_fits;

  always_comb begin
    qmag   = {1'b0, dmag};
    q_s    = (sp ^ sb) ? -qmag : qmag;
    r_s    = sp ? -prem : prem;
    q_fits = (q_s[WD:W_IN-1] == '0) || (q_s[WD:W_IN-1] == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sp          <= 1'b0;
      sb          <= 1'b0;
      dmag        <= '0;
      bmag        <= '0;
      prem        <= '0;
      prod_lo     <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_r         <= '0;
      rem_r       <= '0;
      ovf_r       <= 1'b0;
      div0_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sp         <= bus.product[WD-1];
            sb         <= bus.b[W_IN-1];
            dmag       <= bus.product[WD-1] ? -bus.product : bus.product;
            bmag       <= bus.b[W_IN-1] ? -bus.b : bus.b;
            div0_r     <= (bus.b == '0);
            prod_lo    <= bus.product[W_IN-1:0];
            prem       <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          prem <= ge ? diff : shl_lo;
          dmag <= {dmag[WD-2:0], ge};
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd15) state <= FIX;
        end
        FIX: begin
          if (div0_r) begin
            a_r   <= '0;
            rem_r <= prod_lo;
            ovf_r <= 1'b0;
          end else begin
            a_r   <= q_s[W_IN-1:0];
            rem_r <= r_s;
            ovf_r <= !q_fits;
          end
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.a         = a_r;
  assign bus.rem       = rem_r;
  assign bus.ovf       = ovf_r;
  assign bus.div0      = div0_r;
endmodule
